cpu6_trap_ctrl: RTL and testbench

Trap sequencer for the cpu6 core. It accepts ECALL, MRET and external-interrupt requests, drains the EX/MEM/WB pipeline through the datapath's empty-pipeline handshake, and writes `mepc`/`mcause`. It then issues a single PC redirect to `mtvec` (trap) or `mepc` (return). It sits beside the datapath: it drives `empty_pipeline_reqE`, `excp_mepc` and `excp_mepc_ena`, and consumes `empty_pipeline_ackW`, `csr_mtvec` and `csr_mepc`.

---
 rtl/cpu6_trap_ctrl_if.sv | 37 +++
 rtl/cpu6_trap_ctrl.sv | 122 ++++++++++++
 tb/tb_cpu6_trap_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_trap_ctrl_if.sv
// rtl/cpu6_trap_ctrl_if.sv - datapath <-> trap sequencer signal bundle
// master = datapath side (requests, acks, CSRs); slave = trap controller.
interface cpu6_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ecall_req;
  logic            mret_req;
  logic            irq;
  logic            irq_en;
  logic [XLEN-1:0] pcE;
  logic [XLEN-1:0] pcnextE;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            empty_pipeline_ackW;
  logic            empty_pipeline_reqE;
  logic [XLEN-1:0] excp_mepc;
  logic            excp_mepc_ena;
  logic [XLEN-1:0] excp_mcause;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ena;
  logic            stall_fetch;
  logic            busy;

  modport master (
    output ecall_req, mret_req, irq, irq_en, pcE, pcnextE,
           csr_mtvec, csr_mepc, empty_pipeline_ackW,
    input  empty_pipeline_reqE, excp_mepc, excp_mepc_ena, excp_mcause,
           redirect_pc, redirect_ena, stall_fetch, busy
  );

  modport slave (
    input  ecall_req, mret_req, irq, irq_en, pcE, pcnextE,
           csr_mtvec, csr_mepc, empty_pipeline_ackW,
    output empty_pipeline_reqE, excp_mepc, excp_mepc_ena, excp_mcause,
           redirect_pc, redirect_ena, stall_fetch, busy
  );
endinterface

// File: rtl/cpu6_trap_ctrl.sv
// rtl/cpu6_trap_ctrl.sv - trap sequencer: drain pipeline, save mepc/mcause, redirect PC
// Moore FSM; every output is a decode of registered state (plus CSR values in REDIRECT).
module cpu6_trap_ctrl #(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 8
) (
  input logic             clk,
  input logic             reset,
  cpu6_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE,
    ST_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_ECALL,
    K_MRET,
    K_IRQ
  } kind_t;

  localparam logic [3:0]      CNT_LAST     = 4'(DRAIN_TIMEOUT - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK   = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] MCAUSE_IRQ   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(11);

  state_t          state, state_n;
  kind_t           kind, kind_n;
  logic [XLEN-1:0] pc_lat, pc_n;
  logic [3:0]      cnt, cnt_n;
  logic            pulse, pulse_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      kind   <= K_NONE;
      pc_lat <= '0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      state  <= state_n;
      kind   <= kind_n;
      pc_lat <= pc_n;
      cnt    <= cnt_n;
      pulse  <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    kind_n  = kind;
    pc_n    = pc_lat;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.ecall_req) begin
          kind_n  = K_ECALL;
          pc_n    = bus.pcE;
          state_n = ST_DRAIN;
        end else if (bus.mret_req) begin
          kind_n  = K_MRET;
          state_n = ST_DRAIN;
        end else if (bus.irq && bus.irq_en) begin
          // The E instruction retires, so the interrupt returns to its successor.
          kind_n  = K_IRQ;
          pc_n    = bus.pcnextE;
          state_n = ST_DRAIN;
        end
        if (state_n == ST_DRAIN) begin
          cnt_n   = '0;
          pulse_n = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Ack beats a coincident timeout so no stray token is injected.
        if (bus.empty_pipeline_ackW) begin
          cnt_n   = '0;
          state_n = (kind == K_MRET) ? ST_REDIRECT : ST_SAVE;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      ST_SAVE:     state_n = ST_REDIRECT;
      ST_REDIRECT: state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.empty_pipeline_reqE = 1'b0;
    bus.excp_mepc           = '0;
    bus.excp_mepc_ena       = 1'b0;
    bus.excp_mcause         = '0;
    bus.redirect_pc         = '0;
    bus.redirect_ena        = 1'b0;
    bus.busy                = (state != ST_IDLE);
    bus.stall_fetch         = (state != ST_IDLE);
    case (state)
      ST_DRAIN: bus.empty_pipeline_reqE = pulse;
      ST_SAVE: begin
        bus.excp_mepc_ena = 1'b1;
        bus.excp_mepc     = pc_lat;
        bus.excp_mcause   = (kind == K_IRQ) ? MCAUSE_IRQ : MCAUSE_ECALL;
      end
      ST_REDIRECT: begin
        // CSRs read live here so writes retired during the drain are seen.
        bus.redirect_ena = 1'b1;
        bus.redirect_pc  = ((kind == K_MRET) ? bus.csr_mepc : bus.csr_mtvec) & ALIGN_MASK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// tb/tb_cpu6_trap_ctrl.sv - bench for cpu6_trap_ctrl: event-timeline model plus directed literal checks
module tb_cpu6_trap_ctrl;

  localparam int TMO     = 8;
  localparam int K_ECALL = 0;
  localparam int K_MRET  = 1;
  localparam int K_IRQ   = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  cpu6_trap_ctrl_if #(.XLEN(32)) bus ();

  cpu6_trap_ctrl #(.XLEN(32), .DRAIN_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: a sequence is a timeline. Draining starts at m_first, tokens every TMO
  // cycles; once ack is seen at m_ack, SAVE/REDIRECT land at fixed offsets.
  int          cyc    = 0;
  bit          m_act  = 1'b0;
  int          m_kind = 0;
  logic [31:0] m_pc   = '0;
  int          m_first = 0;
  int          m_ack  = -1;

  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (bus.ecall_req || bus.mret_req || (bus.irq && bus.irq_en)) begin
        m_act   <= 1'b1;
        m_first <= cyc + 1;
        m_ack   <= -1;
        if (bus.ecall_req) begin
          m_kind <= K_ECALL;
          m_pc   <= bus.pcE;
        end else if (bus.mret_req) begin
          m_kind <= K_MRET;
        end else begin
          m_kind <= K_IRQ;
          m_pc   <= bus.pcnextE;
        end
      end
    end else if (m_ack < 0) begin
      if (bus.empty_pipeline_ackW) m_ack <= cyc;
    end else if (cyc == m_ack + ((m_kind == K_MRET) ? 1 : 2)) begin
      m_act <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_busy, e_req, e_save, e_redir;
      logic [31:0] e_mepc, e_mcause, e_rpc;
      e_busy = m_act; e_req = 0; e_save = 0; e_redir = 0;
      e_mepc = 0; e_mcause = 0; e_rpc = 0;
      if (m_act) begin
        if (m_ack < 0) begin
          e_req = ((cyc - m_first) % TMO) == 0;
        end else if (m_kind != K_MRET && cyc == m_ack + 1) begin
          e_save   = 1;
          e_mepc   = m_pc;
          e_mcause = (m_kind == K_IRQ) ? 32'h8000_000B : 32'h0000_000B;
        end else if (cyc == m_ack + ((m_kind == K_MRET) ? 1 : 2)) begin
          e_redir = 1;
          e_rpc   = ((m_kind == K_MRET) ? bus.csr_mepc : bus.csr_mtvec) & 32'hFFFF_FFFC;
        end
      end
      cmp("busy",          32'(bus.busy),                e_busy);
      cmp("stall_fetch",   32'(bus.stall_fetch),         e_busy);
      cmp("req",           32'(bus.empty_pipeline_reqE), e_req);
      cmp("mepc_ena",      32'(bus.excp_mepc_ena),       e_save);
      cmp("mepc",          bus.excp_mepc,                e_mepc);
      cmp("mcause",        bus.excp_mcause,              e_mcause);
      cmp("redirect_ena",  32'(bus.redirect_ena),        e_redir);
      cmp("redirect_pc",   bus.redirect_pc,              e_rpc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    bus.ecall_req = 0; bus.mret_req = 0; bus.irq = 0; bus.irq_en = 0;
    bus.empty_pipeline_ackW = 0;
  endtask

  initial begin
    clr();
    bus.pcE = 0; bus.pcnextE = 0; bus.csr_mtvec = 0; bus.csr_mepc = 0;
    reset = 1;
    step();
    chk_en = 1;
    step();
    at_neg();
    cmp("lit_reset_busy", 32'(bus.busy), 0);
    cmp("lit_reset_redir", 32'(bus.redirect_ena), 0);
    step();
    reset = 0;

    // ECALL, ack at T+2
    bus.pcE = 32'h100; bus.csr_mtvec = 32'h80; bus.csr_mepc = 32'h104; bus.ecall_req = 1;
    step(); bus.ecall_req = 0;
    at_neg(); cmp("lit_ecall_req_t1", 32'(bus.empty_pipeline_reqE), 1);
    cmp("lit_ecall_stall_t1", 32'(bus.stall_fetch), 1);
    step(); bus.empty_pipeline_ackW = 1;
    at_neg(); cmp("lit_ecall_req_t2", 32'(bus.empty_pipeline_reqE), 0);
    step(); bus.empty_pipeline_ackW = 0;
    at_neg(); cmp("lit_ecall_save", 32'(bus.excp_mepc_ena), 1);
    cmp("lit_ecall_mepc", bus.excp_mepc, 32'h100);
    cmp("lit_ecall_mcause", bus.excp_mcause, 32'hB);
    step();
    at_neg(); cmp("lit_ecall_redir", 32'(bus.redirect_ena), 1);
    cmp("lit_ecall_rpc", bus.redirect_pc, 32'h80);
    step();
    at_neg(); cmp("lit_ecall_idle", 32'(bus.busy), 0);

    // MRET
    step(); bus.mret_req = 1;
    step(); bus.mret_req = 0;
    step(); bus.empty_pipeline_ackW = 1;
    step(); bus.empty_pipeline_ackW = 0;
    at_neg(); cmp("lit_mret_redir", 32'(bus.redirect_ena), 1);
    cmp("lit_mret_rpc", bus.redirect_pc, 32'h104);
    cmp("lit_mret_nosave", 32'(bus.excp_mepc_ena), 0);
    step();

    // IRQ enabled, then masked
    bus.irq = 1; bus.irq_en = 1; bus.pcnextE = 32'h200;
    step(); bus.irq = 0;
    step(); bus.empty_pipeline_ackW = 1;
    step(); bus.empty_pipeline_ackW = 0;
    at_neg(); cmp("lit_irq_mepc", bus.excp_mepc, 32'h200);
    cmp("lit_irq_mcause", bus.excp_mcause, 32'h8000_000B);
    step(); step();
    bus.irq = 1; bus.irq_en = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      at_neg(); cmp("lit_irq_masked_busy", 32'(bus.busy), 0);
    end
    bus.irq = 0;

    // Ack withheld: token re-issued every TMO cycles
    step(); bus.ecall_req = 1; bus.pcE = 32'h140;
    for (int k = 1; k <= 20; k++) begin
      step(); bus.ecall_req = 0;
      if (k == 20) bus.empty_pipeline_ackW = 1;
      at_neg();
      cmp("lit_timeout_req", 32'(bus.empty_pipeline_reqE), 32'(k == 1 || k == 9 || k == 17));
    end
    step(); bus.empty_pipeline_ackW = 0;
    at_neg(); cmp("lit_timeout_save", 32'(bus.excp_mepc_ena), 1);
    step(); step();

    // ECALL and IRQ together; IRQ taken after the ECALL sequence
    bus.ecall_req = 1; bus.irq = 1; bus.irq_en = 1; bus.pcE = 32'h300; bus.pcnextE = 32'h304;
    step(); bus.ecall_req = 0;
    step(); bus.empty_pipeline_ackW = 1;
    step(); bus.empty_pipeline_ackW = 0;
    at_neg(); cmp("lit_both_mcause", bus.excp_mcause, 32'hB);
    cmp("lit_both_mepc", bus.excp_mepc, 32'h300);
    step();
    step();
    at_neg(); cmp("lit_both_idle", 32'(bus.busy), 0);
    step(); bus.irq = 0;
    at_neg(); cmp("lit_irq_after_req", 32'(bus.empty_pipeline_reqE), 1);
    step(); bus.empty_pipeline_ackW = 1;
    step(); bus.empty_pipeline_ackW = 0;
    at_neg(); cmp("lit_irq_after_mcause", bus.excp_mcause, 32'h8000_000B);
    cmp("lit_irq_after_mepc", bus.excp_mepc, 32'h304);
    step(); step();

    // Reset in SAVE aborts the sequence
    clr(); bus.ecall_req = 1;
    step(); bus.ecall_req = 0;
    step(); bus.empty_pipeline_ackW = 1;
    step(); bus.empty_pipeline_ackW = 0; reset = 1;
    at_neg(); cmp("lit_rst_save", 32'(bus.excp_mepc_ena), 1);
    step(); reset = 0;
    at_neg(); cmp("lit_rst_noredir", 32'(bus.redirect_ena), 0);
    cmp("lit_rst_busy", 32'(bus.busy), 0);
    step();
    at_neg(); cmp("lit_rst_noredir2", 32'(bus.redirect_ena), 0);

    // Stray ack in IDLE
    bus.empty_pipeline_ackW = 1;
    step(); bus.empty_pipeline_ackW = 0;
    at_neg(); cmp("lit_stray_ack", 32'(bus.busy), 0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      step();
      reset                   = ($urandom_range(0, 299) == 0);
      bus.ecall_req           = ($urandom_range(0, 9) == 0);
      bus.mret_req            = ($urandom_range(0, 9) == 0);
      bus.irq                 = ($urandom_range(0, 5) == 0);
      bus.irq_en              = $urandom_range(0, 1) == 1;
      bus.empty_pipeline_ackW = ($urandom_range(0, 6) == 0);
      bus.pcE                 = $urandom;
      bus.pcnextE             = $urandom;
      bus.csr_mtvec           = $urandom;
      bus.csr_mepc            = $urandom;
    end
    step();
    at_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
